load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle initiator for the word-addressed data memory (async read, write on posedge clk).
//  Executes LW/LH/LHU/LB/LBU/SW/SH/SB for the datapath, extracting and sign-extending loads.
//  Performs read-modify-write for sub-word stores. Start/done handshake matches the multiplier style.
// PARAMETERS
//  (none) data width is fixed at 32; addresses are 32-bit byte addresses.
// PORTS
//  clk        in   1   single clock, all state on posedge
//  R          in   1   asynchronous, active-high reset
//  req        in   1   start request, sampled only in IDLE
//  is_store   in   1   1 = store, 0 = load
//  size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  is_signed  in   1   loads: 1 = sign-extend, 0 = zero-extend
//  addr       in   32  byte address
//  wdata      in   32  store data (byte/half in low bits)
//  rdata      out  32  load result, valid while done=1, held until next load completes
//  done       out  1   one-cycle completion pulse
//  busy       out  1   high in every state except IDLE
//  err        out  1   misaligned/illegal flag, valid with done
//  mem_addr   out  32  word-aligned address to memory ({addr_q[31:2],2'b00})
//  mem_wdata  out  32  word to write
//  mem_write  out  1   write enable to memory
//  mem_rdata  in   32  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  Reset: state=IDLE; rdata, done, busy, err, mem_write, mem_addr, mem_wdata all 0.
//  req sampled at edge N in IDLE: addr/wdata/size/is_signed/is_store captured into regs.
//  FSM IDLE->READ->DONE (load); IDLE->WRITE->DONE (SW); IDLE->READ->WRITE->DONE (SH/SB);
//    IDLE->DONE with err=1 on misalignment (no memory access). DONE->IDLE unconditionally.
//  Latency from accepting edge N: load and SW done in cycle N+2; SH/SB done in cycle N+3.
//  READ: rdata/merge word captured from mem_rdata at end of cycle. WRITE: mem_write=1 one cycle.
//  mem_write is decoded from state only, so R deasserts it immediately (no write at next edge).
//  Byte order big-endian: addr[1:0]=00 -> bits 31:24, 11 -> bits 7:0; half addr[1]=0 -> 31:16.
//  Store merge: only the addressed lane replaced with wdata[7:0]/[15:0]; other lanes keep read value.
//  req ignored while busy; req held high is re-accepted in the IDLE cycle after DONE.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0, any size=11.
//  Reset mid-operation: abort immediately to IDLE, no done pulse, no write.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined: misaligned/illegal requests -> DONE with err=1, no memory access.
//  Not defined: err tied 0; address forced to natural alignment (half clears addr[0], word clears
//    addr[1:0]); size=11 treated as word.
// STRUCTURE
//  Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings.
//  Sub-module lsu_lane: combinational lane extract/sign-extend and store merge, instanced once.
// TESTING
//  1 LW addr 0x10, mem[4]=0x8899AABB -> done in cycle 2 after accept, rdata=0x8899AABB, err=0.
//  2 LB signed addr 0x11 -> rdata=0xFFFFFF99; LBU same address -> 0x00000099; LH 0x12 -> 0xFFFFAABB.
//  3 SB addr 0x12 wdata=0xC3, mem[4]=0x8899AABB -> mem_write in cycle 2, mem[4]=0x8899C3BB, done cycle 3.
//  4 SH addr 0x13: with macro -> done cycle 1, err=1, mem_write never high; without -> writes lane 0x12.
//  5 R asserted during WRITE of SW -> mem_write drops same cycle, mem unchanged, all outputs 0.
//  6 req held high for LW stream -> accepts every 3 cycles, busy low exactly one cycle between ops.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, access-size and FSM encodings,
// and the natural-alignment rule for a request.
package load_store_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when the access is not naturally aligned or the size code is illegal.
  function automatic logic is_misaligned(input size_e sz, input logic [OFF_W-1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response channel plus the data-memory bus of the load/store unit.
//  slave  : the LSU view (takes requests, drives the memory bus)
//  master : the datapath + memory view (issues requests, returns mem_rdata)
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic              req;
  logic              is_store;
  logic [1:0]        size;
  logic              is_signed;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, is_store, size, is_signed, addr, wdata, mem_rdata,
    output rdata, done, busy, err, mem_addr, mem_wdata, mem_write
  );

  modport master (
    output req, is_store, size, is_signed, addr, wdata, mem_rdata,
    input  rdata, done, busy, err, mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/load_store_unit_lane.sv
// Lane unit: big-endian byte/half extraction with sign/zero extension for loads,
// and addressed-lane replacement of a read word for sub-word stores. Purely combinational.
// Ports:
//  word         in  32  word read from memory
//  wdata        in  32  store data, byte/half in the low bits
//  off          in  2   byte offset within the word
//  size         in  2   access size (byte/half/word)
//  is_signed    in  1   sign-extend loads when set
//  load_data_c  out 32  extended load result
//  merge_data_c out 32  word to write back for a store
module load_store_unit_lane
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Offset 0 is the most significant lane.
  always_comb begin
    byte_sel     = word[31:24];
    half_sel     = word[31:16];
    load_data_c  = word;
    merge_data_c = wdata;

    case (off)
      2'b00:   byte_sel = word[31:24];
      2'b01:   byte_sel = word[23:16];
      2'b10:   byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[15:0] : word[31:16];

    case (size)
      SZ_BYTE: begin
        load_data_c  = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
        merge_data_c = word;
        case (off)
          2'b00:   merge_data_c[31:24] = wdata[7:0];
          2'b01:   merge_data_c[23:16] = wdata[7:0];
          2'b10:   merge_data_c[15:8]  = wdata[7:0];
          default: merge_data_c[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data_c  = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
        merge_data_c = word;
        if (off[1]) merge_data_c[15:0]  = wdata[15:0];
        else        merge_data_c[31:16] = wdata[15:0];
      end
      default: begin
        load_data_c  = word;
        merge_data_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory (async read,
// write on posedge clk). Sub-word stores are done as read-modify-write.
// Build option: LSU_ALIGN_CHECK_EN -- when defined, misaligned or illegal-size
// requests complete with err=1 and no memory access; otherwise err is 0, the
// address is forced to natural alignment and size 11 behaves as a word.
// Ports:
//  clk  in  clock, all state on posedge
//  R    in  asynchronous active-high reset
//  bus  slave modport: req/is_store/size/is_signed/addr/wdata in,
//       rdata/done/busy/err out, mem_addr/mem_wdata/mem_write out, mem_rdata in
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic               clk,
  input  logic               R,
  load_store_unit_if.slave   bus
);

  state_e             state_q;
  logic [OFF_W-1:0]   off_q;
  size_e              size_q;
  logic               signed_q;
  logic               store_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               done_q;
  logic               busy_q;
  logic               err_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  size_e              req_size;
  size_e              eff_size;
  logic [OFF_W-1:0]   eff_off;
  logic               req_bad;
  logic [DATA_W-1:0]  load_data_c;
  logic [DATA_W-1:0]  merge_data_c;

  // Request decode: either flag misalignment or coerce the request to alignment.
  always_comb begin
    req_size = size_e'(bus.size);
`ifdef LSU_ALIGN_CHECK_EN
    eff_size = req_size;
    eff_off  = bus.addr[OFF_W-1:0];
    req_bad  = is_misaligned(req_size, bus.addr[OFF_W-1:0]);
`else
    req_bad = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        eff_size = SZ_BYTE;
        eff_off  = bus.addr[OFF_W-1:0];
      end
      SZ_HALF: begin
        eff_size = SZ_HALF;
        eff_off  = {bus.addr[1], 1'b0};
      end
      default: begin
        eff_size = SZ_WORD;
        eff_off  = 2'b00;
      end
    endcase
`endif
  end

  load_store_unit_lane u_lane (
    .word         (bus.mem_rdata),
    .wdata        (wdata_q),
    .off          (off_q),
    .size         (size_q),
    .is_signed    (signed_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Sequencer: IDLE -> READ -> DONE (load), IDLE -> WRITE -> DONE (word store),
  // IDLE -> READ -> WRITE -> DONE (sub-word store), IDLE -> DONE (rejected).
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            off_q      <= eff_off;
            size_q     <= eff_size;
            signed_q   <= bus.is_signed;
            store_q    <= bus.is_store;
            wdata_q    <= bus.wdata;
            mem_addr_q <= {bus.addr[ADDR_W-1:OFF_W], 2'b00};
            busy_q     <= 1'b1;
            if (req_bad) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.is_store && (eff_size == SZ_WORD)) begin
              mem_wdata_q <= bus.wdata;
              state_q     <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (store_q) begin
            mem_wdata_q <= merge_data_c;
            state_q     <= ST_WRITE;
          end else begin
            rdata_q <= load_data_c;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_WRITE: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write strobe comes straight from the state flop so reset kills it at once.
  assign bus.mem_write = (state_q == ST_WRITE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk;
  logic R;
  int   n_cmp;
  int   n_err;

  logic [31:0] mem [64];
  logic        pl_we;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .R   (R),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge; preload port for setup.
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    else if (pl_we)    mem[pl_idx] <= pl_val;
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_we  = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_idle_wait: busy stuck at %b, required 0", bus.busy);
    end
    bus.is_store  = st;
    bus.size      = sz;
    bus.is_signed = sg;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.req       = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(output int lat, output int wr_first, output int wr_cnt,
                           output logic [31:0] rd, output logic er);
    lat = 0; wr_first = 0; wr_cnt = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.mem_write === 1'b1) begin
        wr_cnt++;
        if (wr_first == 0) wr_first = i;
      end
      if (bus.done === 1'b1) begin
        lat = i;
        rd  = bus.rdata;
        er  = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rdata !== 32'h0)     begin n_err++; $display("FAIL reset_rdata: got %h required 0", bus.rdata); end
    n_cmp++; if (bus.done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b required 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.err !== 1'b0)        begin n_err++; $display("FAIL reset_err: got %b required 0", bus.err); end
    n_cmp++; if (bus.mem_write !== 1'b0)  begin n_err++; $display("FAIL reset_mem_write: got %b required 0", bus.mem_write); end
    n_cmp++; if (bus.mem_addr !== 32'h0)  begin n_err++; $display("FAIL reset_mem_addr: got %h required 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h required 0", bus.mem_wdata); end
    R = 1'b0;
  endtask

  task automatic test_lw();
    int lat, wf, wc; logic [31:0] rd; logic er;
    preload(6'd4, 32'h8899AABB);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (lat !== 2)            begin n_err++; $display("FAIL lw_latency: got %0d required 2", lat); end
    n_cmp++; if (rd !== 32'h8899AABB)  begin n_err++; $display("FAIL lw_rdata: got %h required 8899aabb", rd); end
    n_cmp++; if (er !== 1'b0)          begin n_err++; $display("FAIL lw_err: got %b required 0", er); end
    n_cmp++; if (wc !== 0)             begin n_err++; $display("FAIL lw_no_write: got %0d writes required 0", wc); end
    n_cmp++; if (bus.mem_addr !== 32'h10) begin n_err++; $display("FAIL lw_mem_addr: got %h required 10", bus.mem_addr); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz [6]  = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE};
    logic        sg [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [6]  = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h13, 32'h10};
    logic [31:0] ex [6]  = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB,
                             32'h00008899, 32'hFFFFFFBB, 32'h00000088};
    int lat, wf, wc; logic [31:0] rd; logic er;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
      wait_done(lat, wf, wc, rd, er);
      n_cmp++;
      if (rd !== ex[i] || lat !== 2 || er !== 1'b0) begin
        n_err++;
        $display("FAIL load_%0d: got rdata %h lat %0d err %b required %h lat 2 err 0",
                 i, rd, lat, er, ex[i]);
      end
    end
  endtask

  task automatic test_sb();
    int lat, wf, wc; logic [31:0] rd; logic er;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000C3);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (wf !== 2)            begin n_err++; $display("FAIL sb_write_cycle: got %0d required 2", wf); end
    n_cmp++; if (wc !== 1)            begin n_err++; $display("FAIL sb_write_count: got %0d required 1", wc); end
    n_cmp++; if (lat !== 3)           begin n_err++; $display("FAIL sb_latency: got %0d required 3", lat); end
    n_cmp++; if (mem[4] !== 32'h8899C3BB) begin n_err++; $display("FAIL sb_mem: got %h required 8899c3bb", mem[4]); end
  endtask

  task automatic test_sw_sh();
    int lat, wf, wc; logic [31:0] rd; logic er;
    issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEADBEEF);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (lat !== 2 || wf !== 1) begin n_err++; $display("FAIL sw_timing: got lat %0d write %0d required lat 2 write 1", lat, wf); end
    n_cmp++; if (mem[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_mem: got %h required deadbeef", mem[5]); end
    issue(1'b1, SZ_HALF, 1'b0, 32'h10, 32'h1111CAFE);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (lat !== 3)           begin n_err++; $display("FAIL sh_latency: got %0d required 3", lat); end
    n_cmp++; if (mem[4] !== 32'hCAFEC3BB) begin n_err++; $display("FAIL sh_mem: got %h required cafec3bb", mem[4]); end
  endtask

  task automatic test_misaligned();
    int lat, wf, wc; logic [31:0] rd; logic er;
    issue(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h00001234);
    wait_done(lat, wf, wc, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    n_cmp++; if (lat !== 1)  begin n_err++; $display("FAIL mis_sh_latency: got %0d required 1", lat); end
    n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL mis_sh_err: got %b required 1", er); end
    n_cmp++; if (wc !== 0)   begin n_err++; $display("FAIL mis_sh_write: got %0d writes required 0", wc); end
    n_cmp++; if (mem[4] !== 32'hCAFEC3BB) begin n_err++; $display("FAIL mis_sh_mem: got %h required cafec3bb", mem[4]); end
    issue(1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (lat !== 1 || er !== 1'b1) begin n_err++; $display("FAIL ill_size: got lat %0d err %b required lat 1 err 1", lat, er); end
`else
    n_cmp++; if (lat !== 3)  begin n_err++; $display("FAIL mis_sh_latency: got %0d required 3", lat); end
    n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL mis_sh_err: got %b required 0", er); end
    n_cmp++; if (wc !== 1)   begin n_err++; $display("FAIL mis_sh_write: got %0d writes required 1", wc); end
    n_cmp++; if (mem[4] !== 32'hCAFE1234) begin n_err++; $display("FAIL mis_sh_mem: got %h required cafe1234", mem[4]); end
    issue(1'b0, SZ_ILL, 1'b0, 32'h11, 32'h0);
    wait_done(lat, wf, wc, rd, er);
    n_cmp++; if (lat !== 2 || er !== 1'b0 || rd !== 32'hCAFE1234) begin
      n_err++; $display("FAIL ill_size: got lat %0d err %b rdata %h required lat 2 err 0 cafe1234", lat, er, rd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    preload(6'd6, 32'h11111111);
    issue(1'b1, SZ_WORD, 1'b0, 32'h18, 32'hAAAAAAAA);
    @(negedge clk);
    n_cmp++; if (bus.mem_write !== 1'b1) begin n_err++; $display("FAIL rmid_write_before: got %b required 1", bus.mem_write); end
    R = 1'b1;
    #1;
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rmid_write_drop: got %b required 0", bus.mem_write); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_err++; $display("FAIL rmid_flags: got busy %b done %b err %b required 0 0 0", bus.busy, bus.done, bus.err);
    end
    n_cmp++; if (bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL rmid_data: got rdata %h mem_addr %h mem_wdata %h required all 0", bus.rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    n_cmp++; if (mem[6] !== 32'h11111111) begin n_err++; $display("FAIL rmid_mem: got %h required 11111111", mem[6]); end
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_after: got done %b busy %b required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] dvec;
    logic [8:0] bvec;
    preload(6'd4, 32'h8899AABB);
    @(negedge clk);
    bus.is_store  = 1'b0;
    bus.size      = SZ_WORD;
    bus.is_signed = 1'b0;
    bus.addr      = 32'h10;
    bus.wdata     = 32'h0;
    bus.req       = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dvec[i] = bus.done;
      bvec[i] = bus.busy;
      if (bus.done === 1'b1) begin
        n_cmp++;
        if (bus.rdata !== 32'h8899AABB) begin n_err++; $display("FAIL b2b_rdata_%0d: got %h required 8899aabb", i, bus.rdata); end
      end
    end
    bus.req = 1'b0;
    n_cmp++; if (dvec !== 9'h092) begin n_err++; $display("FAIL b2b_done_pattern: got %b required %b", dvec, 9'h092); end
    n_cmp++; if (bvec !== 9'h0DB) begin n_err++; $display("FAIL b2b_busy_pattern: got %b required %b", bvec, 9'h0DB); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after: got %b required 0", bus.busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    pl_we = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00;
    bus.is_signed = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_lw();
    test_loads();
    test_sb();
    test_sw_sh();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
